// File: rtl/audio_rom_player.sv
// audio_rom_player
//   Streams 16-bit PCM words out of the on-chip sample ROM (1-cycle read
//   latency) onto an Avalon-ST source, in address order, over an inclusive
//   address window. Supports play-once or loop, stop/abort, and sink
//   backpressure through a 2-entry output FIFO.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   start/stop/loop_en         control (start ignored while busy, stop wins)
//   start_addr/end_addr        inclusive window, latched on accepted start
//   rom_address/rom_chipselect/rom_clken/rom_readdata   ROM read master
//   out_data/out_valid/out_ready                        Avalon-ST source
//   busy/done/err              status (done/err are one-cycle pulses)
module audio_rom_player #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 240256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH_WORDS);

  state_t            r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_end;
  logic              r_inflight;
  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_d0;      // FIFO head, drives out_data directly
  logic [DATA_W-1:0] r_d1;
  logic              r_valid;
  logic              r_done;
  logic              r_err;

  logic              w_pop;
  logic              w_push;
  logic [2:0]        w_occ;
  logic              w_issue;
  logic              w_bad;
  logic [1:0]        w_cnt_n;
  logic [DATA_W-1:0] w_d0_n;
  logic [DATA_W-1:0] w_d1_n;

  assign w_pop  = r_valid & out_ready;
  assign w_push = r_inflight;

  // Words already owed to the FIFO after this cycle's pop. Issuing only when
  // this is below 2 guarantees the in-flight word always has a slot, so no
  // sample is ever dropped even under sustained backpressure.
  assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = (r_state == S_PLAY) && !stop && !reset && (w_occ < 3'd2);

  assign w_bad = (start_addr > end_addr) || ({1'b0, end_addr} >= DEPTH_L);

  // FIFO next-state: head register stays put unless popped, so out_data is
  // stable while the sink stalls.
  always_comb begin
    w_d0_n  = r_d0;
    w_d1_n  = r_d1;
    w_cnt_n = r_count;
    unique case ({w_push, w_pop})
      2'b10: begin
        if (r_count == 2'd0) w_d0_n = rom_readdata;
        else                 w_d1_n = rom_readdata;
        w_cnt_n = r_count + 2'd1;
      end
      2'b01: begin
        if (r_count == 2'd2) w_d0_n = r_d1;
        w_cnt_n = r_count - 2'd1;
      end
      2'b11: begin
        if (r_count == 2'd1) begin
          w_d0_n = rom_readdata;
        end else begin
          w_d0_n = r_d1;
          w_d1_n = rom_readdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_start    <= '0;
      r_end      <= '0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_inflight <= w_issue;
      r_count    <= w_cnt_n;
      r_d0       <= w_d0_n;
      r_d1       <= w_d1_n;
      r_valid    <= (w_cnt_n != 2'd0);

      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            if (w_bad) begin
              r_err <= 1'b1;
            end else begin
              r_start <= start_addr;
              r_end   <= end_addr;
              r_ptr   <= start_addr;
              r_state <= S_PLAY;
            end
          end
        end
        S_PLAY: begin
          if (w_issue) begin
            if (r_ptr != r_end)  r_ptr   <= r_ptr + 1'b1;
            else if (loop_en)    r_ptr   <= r_start;
            else                 r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_count == 2'd0 && !r_inflight) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Abort overrides everything above: drop buffered and in-flight words.
      if (stop && r_state != S_IDLE) begin
        r_state    <= S_IDLE;
        r_count    <= 2'd0;
        r_valid    <= 1'b0;
        r_inflight <= 1'b0;
        r_done     <= 1'b0;
      end
    end
  end

  assign rom_address    = r_ptr;
  assign rom_chipselect = w_issue;
  assign rom_clken      = w_issue;
  assign out_data       = r_d0;
  assign out_valid      = r_valid;
  assign busy           = (r_state != S_IDLE);
  assign done           = r_done;
  assign err            = r_err;

endmodule

// File: tb/tb_audio_rom_player.sv
module tb_audio_rom_player;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 240256;

  logic              clk;
  logic              reset;
  logic              start, stop, loop_en;
  logic [ADDR_W-1:0] start_addr, end_addr;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_chipselect, rom_clken;
  logic [DATA_W-1:0] rom_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_ready;
  logic              busy, done, err;

  audio_rom_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
    .start_addr(start_addr), .end_addr(end_addr),
    .rom_address(rom_address), .rom_chipselect(rom_chipselect), .rom_clken(rom_clken),
    .rom_readdata(rom_readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: word n holds n (low 16 bits), 1-cycle latency, holds when clken=0
  always @(posedge clk) if (rom_clken) rom_readdata <= rom_address[15:0];

  int pass_cnt = 0, total_cnt = 0;
  int cyc = 0;
  int ready_mode = 0;     // 0: always 1, 1: 1,0,0,1 pattern, 2: random, 3: always 0
  int pat_i = 0;
  logic [DATA_W-1:0] got_q[$];
  int got_cyc[$];
  int done_cnt, err_cnt, cs_cnt, busy_seen, first_cs_cyc, first_valid_cyc, err_cyc;
  int occ = 0, occ_viol, done_busy_viol, clken_viol;
  logic [ADDR_W-1:0] first_cs_addr;

  task automatic clear();
    got_q.delete(); got_cyc.delete();
    done_cnt = 0; err_cnt = 0; cs_cnt = 0; busy_seen = 0;
    first_cs_cyc = -1; first_valid_cyc = -1; err_cyc = -1; first_cs_addr = '0;
    occ_viol = 0; done_busy_viol = 0; clken_viol = 0; pat_i = 0;
  endtask

  // Observe the current cycle (handshakes resolve at the coming edge), then advance.
  task automatic cycle();
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin out_ready = (pat_i % 4 == 0) || (pat_i % 4 == 3); pat_i++; end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
    #1;
    if (out_valid && out_ready) begin got_q.push_back(out_data); got_cyc.push_back(cyc); end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (rom_chipselect) begin
      cs_cnt++;
      if (first_cs_cyc < 0) begin first_cs_cyc = cyc; first_cs_addr = rom_address; end
    end
    if (rom_chipselect !== rom_clken) clken_viol++;
    if (done) begin done_cnt++; if (busy) done_busy_viol++; end
    if (err) begin err_cnt++; if (err_cyc < 0) err_cyc = cyc; end
    if (busy) busy_seen++;
    occ = occ + (rom_chipselect ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    if (occ > 2 || occ < 0) occ_viol++;
    if (reset || (stop && busy)) occ = 0;
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic run_until_done(int budget);
    for (int n = 0; n < budget && done_cnt == 0; n++) cycle();
  endtask

  task automatic kick(logic [ADDR_W-1:0] sa, logic [ADDR_W-1:0] ea, logic le, output int s);
    start_addr = sa; end_addr = ea; loop_en = le; start = 1'b1;
    s = cyc; cycle(); start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    total_cnt++;
    if ({rom_address, rom_chipselect, rom_clken, out_valid, out_data, busy, done, err} !== '0)
      $display("FAIL reset_state got addr=%0d cs=%b ck=%b v=%b d=%0d busy=%b done=%b err=%b expected all 0",
               rom_address, rom_chipselect, rom_clken, out_valid, out_data, busy, done, err);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    int s;
    clear(); ready_mode = 0;
    kick(10, 13, 1'b0, s);
    run_until_done(60);
    repeat (3) cycle();
    total_cnt++;
    if (got_q.size() !== 4) $display("FAIL basic_count got %0d expected 4", got_q.size()); else pass_cnt++;
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      total_cnt++;
      if (got_q[i] !== 16'(10 + i)) $display("FAIL basic_data[%0d] got %0d expected %0d", i, got_q[i], 10 + i);
      else pass_cnt++;
    end
    total_cnt++;
    if (first_cs_cyc !== s + 1 || first_cs_addr !== 18'd10)
      $display("FAIL basic_first_issue got cyc=%0d addr=%0d expected cyc=%0d addr=10", first_cs_cyc, first_cs_addr, s + 1);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() > 0 && got_cyc[0] !== s + 3)
      $display("FAIL basic_latency got first valid cyc %0d expected %0d", got_cyc[0], s + 3);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() == 4 && got_cyc[3] - got_cyc[0] !== 3)
      $display("FAIL basic_consecutive got span %0d expected 3", got_cyc[3] - got_cyc[0]);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1 || done_busy_viol !== 0 || busy !== 1'b0)
      $display("FAIL basic_done got done=%0d busy_at_done=%0d busy=%b expected 1,0,0", done_cnt, done_busy_viol, busy);
    else pass_cnt++;
  endtask

  task automatic test_toggle();
    int s, bad;
    clear(); ready_mode = 1; bad = 0;
    kick(10, 13, 1'b0, s);
    run_until_done(100);
    ready_mode = 0; repeat (2) cycle();
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'(10 + i)) bad++;
    total_cnt++;
    if (got_q.size() !== 4 || bad !== 0) $display("FAIL toggle_seq got %0d samples %0d wrong expected 4 samples 10..13", got_q.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (occ_viol !== 0 || clken_viol !== 0) $display("FAIL toggle_occupancy got overfill=%0d clken_diff=%0d expected 0,0", occ_viol, clken_viol);
    else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL toggle_done got %0d expected 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_loop();
    int s, bad, gaps;
    clear(); ready_mode = 0; bad = 0; gaps = 0;
    kick(100, 101, 1'b1, s);
    for (int n = 0; n < 100 && got_q.size() < 10; n++) cycle();
    loop_en = 1'b0;
    run_until_done(60);
    repeat (2) cycle();
    for (int i = 0; i < got_q.size(); i++) begin
      if (got_q[i] !== 16'(100 + i % 2)) bad++;
      if (i > 0 && got_cyc[i] != got_cyc[i-1] + 1) gaps++;
    end
    total_cnt++;
    if (got_q.size() < 10 || bad !== 0) $display("FAIL loop_seq got %0d samples %0d wrong expected >=10 alternating 100,101", got_q.size(), bad);
    else pass_cnt++;
    total_cnt++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== 16'd101) $display("FAIL loop_last got %0d expected 101", got_q.size() ? got_q[got_q.size()-1] : 16'hxxxx);
    else pass_cnt++;
    total_cnt++;
    if (gaps !== 0) $display("FAIL loop_gaps got %0d expected 0", gaps); else pass_cnt++;
    total_cnt++;
    if (done_cnt !== 1) $display("FAIL loop_done got %0d expected 1", done_cnt); else pass_cnt++;
  endtask

  task automatic test_err(logic [ADDR_W-1:0] sa, logic [ADDR_W-1:0] ea, string nm);
    int s;
    clear(); ready_mode = 0;
    kick(sa, ea, 1'b0, s);
    repeat (4) cycle();
    total_cnt++;
    if (err_cnt !== 1 || err_cyc !== s + 1) $display("FAIL %s_err got pulses=%0d at %0d expected 1 at %0d", nm, err_cnt, err_cyc, s + 1);
    else pass_cnt++;
    total_cnt++;
    if (busy_seen !== 0 || cs_cnt !== 0) $display("FAIL %s_idle got busy_cycles=%0d issues=%0d expected 0,0", nm, busy_seen, cs_cnt);
    else pass_cnt++;
  endtask

  task automatic test_stop();
    int s;
    clear(); ready_mode = 0;
    kick(20, 40, 1'b0, s);
    for (int n = 0; n < 20 && first_valid_cyc < 0; n++) cycle();
    cycle();
    stop = 1'b1; cycle(); stop = 1'b0;
    total_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL stop_flush got valid=%b busy=%b expected 0,0", out_valid, busy);
    else pass_cnt++;
    repeat (4) cycle();
    total_cnt++;
    if (done_cnt !== 0 || out_valid !== 1'b0) $display("FAIL stop_nodone got done=%0d valid=%b expected 0,0", done_cnt, out_valid);
    else pass_cnt++;
    clear();
    kick(0, 0, 1'b0, s);
    run_until_done(40);
    repeat (2) cycle();
    total_cnt++;
    if (got_q.size() !== 1 || got_q[0] !== 16'd0 || done_cnt !== 1)
      $display("FAIL stop_restart got %0d samples done=%0d expected one sample 0 and done", got_q.size(), done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int s;
    clear(); ready_mode = 3;
    kick(50, 60, 1'b0, s);
    repeat (6) cycle();
    reset = 1'b1; cycle(); reset = 1'b0;
    total_cnt++;
    if ({rom_address, rom_chipselect, rom_clken, out_valid, out_data, busy, done, err} !== '0)
      $display("FAIL reset_mid got addr=%0d cs=%b v=%b d=%0d busy=%b done=%b err=%b expected all 0",
               rom_address, rom_chipselect, out_valid, out_data, busy, done, err);
    else pass_cnt++;
    clear(); ready_mode = 0;
    start_addr = 3; end_addr = 7; start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    repeat (5) cycle();
    total_cnt++;
    if (cs_cnt !== 0 || busy_seen !== 0 || err_cnt !== 0 || got_q.size() !== 0)
      $display("FAIL start_stop_idle got issues=%0d busy=%0d err=%0d samples=%0d expected all 0", cs_cnt, busy_seen, err_cnt, got_q.size());
    else pass_cnt++;
  endtask

  // Random windows, random backpressure, some looping; chained back to back.
  task automatic test_back_to_back();
    int s, len, bad, want;
    logic [ADDR_W-1:0] sa;
    logic le;
    for (int it = 0; it < 8; it++) begin
      clear(); ready_mode = 2; bad = 0;
      len = $urandom_range(1, 8);
      sa  = (it == 0) ? ADDR_W'(DEPTH - len) : ADDR_W'($urandom_range(0, DEPTH - 9));
      le  = it[0];
      kick(sa, sa + ADDR_W'(len - 1), le, s);
      if (le) begin
        want = 2 * len + $urandom_range(0, 3);
        for (int n = 0; n < 400 && got_q.size() < want; n++) cycle();
        loop_en = 1'b0;
      end
      run_until_done(400);
      for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 16'(sa + ADDR_W'(i % len))) bad++;
      total_cnt++;
      if (first_cs_cyc !== s + 1) $display("FAIL b2b_accept[%0d] got first issue %0d expected %0d", it, first_cs_cyc, s + 1);
      else pass_cnt++;
      total_cnt++;
      if (bad !== 0 || got_q.size() == 0 || got_q.size() % len != 0 || (!le && got_q.size() != len))
        $display("FAIL b2b_seq[%0d] got %0d samples %0d wrong expected whole windows of %0d from %0d", it, got_q.size(), bad, len, sa);
      else pass_cnt++;
      total_cnt++;
      if (done_cnt !== 1 || occ_viol !== 0 || done_busy_viol !== 0)
        $display("FAIL b2b_status[%0d] got done=%0d overfill=%0d busy_at_done=%0d expected 1,0,0", it, done_cnt, occ_viol, done_busy_viol);
      else pass_cnt++;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    start_addr = '0; end_addr = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_toggle();
    test_loop();
    test_err(18'd5, 18'd4, "order");
    test_err(18'd0, 18'd240256, "range");
    test_stop();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/audio_rom_player.md
# audio_rom_player

Streaming reader for the on-chip audio sample ROM. It acts as the Avalon-MM read master that fetches 16-bit PCM words from the ROM's single read port, which has 1-cycle latency. It delivers the words in address order on an Avalon-ST source, either to the codec's sample FIFO or to its serializer. Playback covers a programmable inclusive address window, can play once or loop, and honours sink backpressure without losing or duplicating samples.

## Interface
Parameters:
- ADDR_W, 18, ROM word-address width
- DATA_W, 16, sample width
- DEPTH_WORDS, 240256, number of valid ROM words; legal addresses are 0..DEPTH_WORDS-1

Ports:
- clk  in  1  single clock for all logic, including the ROM
- reset  in  1  synchronous, active-high; clears all state on the clk edge where it is sampled high
- start  in  1  one-cycle request to begin playback; ignored while busy
- stop  in  1  one-cycle abort request
- loop_en  in  1  when 1, playback wraps from end_addr back to start_addr; sampled on every wrap decision
- start_addr  in  ADDR_W  first word of the window; latched when start is accepted
- end_addr  in  ADDR_W  last word of the window, inclusive; latched when start is accepted
- rom_address  out  ADDR_W  ROM word address
- rom_chipselect  out  1  read-issue strobe
- rom_clken  out  1  ROM clock enable; same value as rom_chipselect, so the ROM address register holds when no read is issued
- rom_readdata  in  DATA_W  ROM data; valid 1 cycle after an issue
- out_data  out  DATA_W  sample at the FIFO head
- out_valid  out  1  out_data is valid
- out_ready  in  1  sink accepts the sample
- busy  out  1  high in PLAY or DRAIN
- done  out  1  one-cycle pulse when a non-looping playback completes
- err  out  1  one-cycle pulse when a start is rejected

## Operation
- States: IDLE, PLAY, DRAIN. Reset puts the block in IDLE with rom_address=0, rom_chipselect=0, rom_clken=0, out_valid=0, out_data=0, busy=0, done=0, err=0, FIFO count=0, inflight=0.
- IDLE, start=1, stop=0:
  - Reject if start_addr>end_addr or end_addr>=DEPTH_WORDS: pulse err, stay in IDLE.
  - Otherwise latch the window, set the next-issue pointer to start_addr, go to PLAY.
- Buffering: a 2-entry output FIFO. inflight = rom_chipselect delayed by 1 cycle. rom_readdata is pushed into the FIFO when inflight=1. A pop occurs when out_valid & out_ready.
- Issue rule, in PLAY only: issue when count + inflight - pop < 2. An issue drives rom_address=pointer and rom_chipselect=rom_clken=1 for that cycle.
- After an issue at the pointer:
  - pointer<end_addr: increment the pointer.
  - pointer==end_addr and loop_en=1: pointer becomes start_addr; stay in PLAY.
  - pointer==end_addr and loop_en=0: go to DRAIN.
- DRAIN: no further issues. When count==0 and inflight==0, pulse done and go to IDLE.
- stop=1 in PLAY or DRAIN: next state is IDLE. FIFO is flushed (count=0), any in-flight word is discarded, out_valid=0, no done pulse.
- stop=1 in IDLE: no effect. stop and start in the same cycle: stop wins, start is ignored.
- start while busy: ignored, no err.
- Data is never reordered. Every issued address is delivered exactly once unless a stop flushes it.

## Timing
- start is high in cycle c. The first rom_chipselect is high in cycle c+1 with rom_address=start_addr. The word is pushed at the end of c+2. out_valid is high from cycle c+3.
- Throughput with out_ready held at 1: one sample per cycle in steady state, with no bubbles across a loop wrap.
- out_valid and out_data are registered outputs. out_data is stable while out_valid=1 and out_ready=0.
- busy falls in the same cycle that done pulses. A new start is accepted the cycle after done.
- reset mid-playback: the next cycle matches the post-reset state exactly.

## Test plan
- Window 10..13, loop_en=0, out_ready=1, ROM word n=n: out_data sequence is 10,11,12,13 on consecutive cycles, first out_valid 3 cycles after start. done pulses once, then busy=0.
- Same window, out_ready toggling 1,0,0,1 repeatedly: the sink receives exactly 10,11,12,13 with no duplicates. The FIFO never exceeds 2 entries and rom_chipselect never issues while the FIFO is full.
- Window 100..101, loop_en=1 for 10 samples, then loop_en=0: output is 100,101,100,101,… and ends after a 101 with a done pulse. No gap at the wrap.
- start_addr=5 with end_addr=4, and separately end_addr=240256: err pulses one cycle, busy stays 0, no ROM issue.
- stop asserted 2 cycles after the first out_valid: out_valid=0 the next cycle, state is IDLE, no done. A restart with window 0..0 yields exactly one sample, word 0.
- reset asserted mid-PLAY while out_ready=0: all outputs are at their reset values the next cycle. start and stop asserted together in IDLE produce no activity.
